periph_to_csb_tracked: RTL

- Parametrised successor to the HWPE-peripheral-to-NVDLA-CSB bridge.
- Converts HWPE periph slave requests into NVDLA CSB transactions.
- Supports multiple outstanding requests through an in-order tracker FIFO, returning the originating periph ID with every response.
- Adds an address window with local error responses, posted and non-posted write modes, and sticky protocol-error flags.
- Sits between the cluster peripheral interconnect and the NVDLA core CSB port.

---
 rtl/periph_csb_pkg.sv | 10 +
 rtl/csb_tracker_fifo.sv | 35 +++
 rtl/periph_to_csb_tracked.sv | 82 ++++++++
 3 files changed

// File: rtl/periph_csb_pkg.sv
// periph_csb_pkg: shared types and helpers for the periph-to-CSB tracked bridge
package periph_csb_pkg;
  typedef enum logic [1:0] {RD = 2'd0, NPW = 2'd1, LOC = 2'd2} entry_kind_e;
  localparam int ERR_SPURIOUS = 0;
  localparam int ERR_TYPE = 1;
  localparam int ERR_BE = 2;
  function automatic entry_kind_e entry_kind(input logic in_win, input logic write, input logic posted);
    return !in_win ? LOC : !write ? RD : posted ? LOC : NPW;
  endfunction
endpackage

// File: rtl/csb_tracker_fifo.sv
// csb_tracker_fifo: in-order tracker FIFO with wrap-bit full/empty detection
module csb_tracker_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout = mem[rd_ptr[AW-1:0]];
  // pointer update; the extra top bit tracks wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  // entry storage needs no reset; validity comes from the pointers
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/periph_to_csb_tracked.sv
// periph_to_csb_tracked: HWPE periph to NVDLA CSB bridge with in-order response tracking
module periph_to_csb_tracked
  import periph_csb_pkg::*;
#(
  parameter int          ID_WIDTH  = 1,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CSB_AW    = 16,
  parameter bit          POSTED_WR = 1'b1,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                periph_req_i,
  input  logic [31:0]         periph_add_i,
  input  logic                periph_wen_i,
  input  logic [3:0]          periph_be_i,
  input  logic [31:0]         periph_data_i,
  input  logic [ID_WIDTH-1:0] periph_id_i,
  output logic                periph_gnt_o,
  output logic [31:0]         periph_r_data_o,
  output logic                periph_r_valid_o,
  output logic [ID_WIDTH-1:0] periph_r_id_o,
  output logic                csb_valid_o,
  input  logic                csb_ready_i,
  output logic [CSB_AW-1:0]   csb_addr_o,
  output logic [31:0]         csb_wdat_o,
  output logic                csb_write_o,
  output logic                csb_nposted_o,
  input  logic                csb_r_valid_i,
  input  logic [31:0]         csb_r_data_i,
  input  logic                csb_wr_complete_i,
  output logic [2:0]          err_o
);
  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    entry_kind_e         kind;
    logic [31:0]         local_data;
  } tracker_entry_t;
  tracker_entry_t din, head;
  entry_kind_e kind;
  logic [31:0] off;
  logic [2:0] err_set;
  logic in_window, is_write, full, empty, pop, head_loc, head_trk, rsp_ok;
  assign off = periph_add_i - BASE_ADDR;
  assign in_window = {1'b0, off} < (33'd4 << CSB_AW);
  assign is_write = !periph_wen_i;
  assign kind = entry_kind(in_window, is_write, POSTED_WR);
  assign din = '{id: periph_id_i, kind: kind, local_data: in_window ? 32'h0 : ERR_DATA};
  assign periph_gnt_o = !rst && periph_req_i && !full && (kind == LOC || csb_ready_i);
  assign csb_valid_o = !rst && periph_req_i && !full && in_window;
  assign csb_addr_o = off[CSB_AW+1:2];
  assign csb_wdat_o = periph_data_i;
  assign csb_write_o = is_write;
  assign csb_nposted_o = is_write && !POSTED_WR;
  assign head_loc = !empty && head.kind == LOC;
  assign head_trk = !empty && head.kind != LOC;
  assign rsp_ok = head_trk && csb_r_valid_i;
  assign pop = head_loc || rsp_ok;
  assign err_set[ERR_SPURIOUS] = csb_r_valid_i && !head_trk;
  assign err_set[ERR_TYPE] = rsp_ok && (csb_wr_complete_i != (head.kind == NPW));
  assign err_set[ERR_BE] = periph_gnt_o && is_write && periph_be_i != 4'hF;
  csb_tracker_fifo #(.W($bits(tracker_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(periph_gnt_o), .pop(pop), .din(din), .dout(head), .full(full), .empty(empty)
  );
  // response register: one-cycle valid pulse, data and id held between completions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      periph_r_valid_o <= 1'b0;
      periph_r_data_o <= '0;
      periph_r_id_o <= '0;
      err_o <= '0;
    end else begin
      periph_r_valid_o <= pop;
      if (pop) begin
        periph_r_id_o <= head.id;
        periph_r_data_o <= head_loc ? head.local_data : csb_r_data_i;
      end
      err_o <= err_o | err_set;
    end
  end
endmodule
